// File: rtl/laser_frame_sched_if.sv
// rtl/laser_frame_sched_if.sv - host point stream, laser core feed, result handshake and status
interface laser_frame_sched_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_x;
  logic [3:0]  in_y;
  logic        core_start;
  logic [3:0]  core_x;
  logic [3:0]  core_y;
  logic        core_done;
  logic [15:0] core_c;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_c;
  logic        busy;
  logic        err;
  logic [7:0]  frame_cnt;

  modport slave (
    input  in_valid, in_x, in_y, core_done, core_c, res_ready,
    output in_ready, core_start, core_x, core_y, res_valid, res_c, busy, err, frame_cnt
  );

  modport master (
    output in_valid, in_x, in_y, core_done, core_c, res_ready,
    input  in_ready, core_start, core_x, core_y, res_valid, res_c, busy, err, frame_cnt
  );
endinterface

// File: rtl/laser_frame_sched.sv
// rtl/laser_frame_sched.sv - buffers one frame of points, streams it to the laser core, returns the result
module laser_frame_sched #(
  parameter int N_PTS = 40,
  parameter int TMO   = 4095
) (
  input logic                CLK,
  input logic                RST,
  laser_frame_sched_if.slave bus
);
  localparam int AW = (N_PTS > 1) ? $clog2(N_PTS) : 1;
  localparam logic [AW-1:0] LAST_PT  = AW'(N_PTS - 1);
  localparam logic [11:0]   TMO_LAST = 12'(TMO - 1);

  typedef enum logic [2:0] {IDLE, FILL, START, STREAM, WAIT, RESULT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [11:0]   tmo_q, tmo_d;
  logic [15:0]   res_c_q, res_c_d;
  logic          err_q, err_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          buf_we;
  logic [7:0]    buf_rd;
  logic [7:0]    buf_q [N_PTS];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      tmo_q       <= '0;
      res_c_q     <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      tmo_q       <= tmo_d;
      res_c_q     <= res_c_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Point storage carries no reset; only entries written in the current frame are ever read.
  always_ff @(posedge CLK) begin
    if (buf_we) begin
      buf_q[wptr_q] <= {bus.in_x, bus.in_y};
    end
  end

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    tmo_d       = tmo_q;
    res_c_d     = res_c_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    buf_we      = 1'b0;
    case (state_q)
      IDLE: state_d = FILL;
      FILL: begin
        if (bus.in_valid) begin
          buf_we = 1'b1;
          wptr_d = wptr_q + AW'(1);
          if (wptr_q == '0) begin
            err_d = 1'b0;
          end
          if (wptr_q == LAST_PT) begin
            state_d = START;
          end
        end
      end
      START: begin
        rptr_d  = '0;
        state_d = STREAM;
      end
      STREAM: begin
        rptr_d = rptr_q + AW'(1);
        if (rptr_q == LAST_PT) begin
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        tmo_d = tmo_q + 12'd1;
        // A completion arriving on the timeout cycle is still a valid result.
        if (bus.core_done) begin
          res_c_d = bus.core_c;
          state_d = RESULT;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          res_c_d = 16'hFFFF;
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (bus.res_ready) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          wptr_d      = '0;
          state_d     = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign buf_rd         = buf_q[rptr_q];
  assign bus.in_ready   = (state_q == FILL);
  assign bus.core_start = (state_q == START);
  assign bus.core_x     = (state_q == STREAM) ? buf_rd[7:4] : 4'd0;
  assign bus.core_y     = (state_q == STREAM) ? buf_rd[3:0] : 4'd0;
  assign bus.res_valid  = (state_q == RESULT);
  assign bus.res_c      = res_c_q;
  assign bus.busy       = (state_q == START) || (state_q == STREAM) || (state_q == WAIT);
  assign bus.err        = err_q;
  assign bus.frame_cnt  = frame_cnt_q;
endmodule

// File: doc/laser_frame_sched.md
LASER_FRAME_SCHED -- requirements
Module: laser_frame_sched

Interface
REQ-001 SHALL have parameter N_PTS, default 40, meaning points per frame (2..63).
REQ-002 SHALL have parameter TMO, default 4095, meaning core-wait timeout in cycles (12-bit).
REQ-003 Port CLK, input, 1: the single clock; all state on its rising edge.
REQ-004 Port RST, input, 1: reset, asynchronous and active-low (asserted at 0).
REQ-005 Ports in_valid in 1, in_ready out 1, in_x in 4, in_y in 4: host point stream.
REQ-006 Ports core_start out 1, core_x out 4, core_y out 4: point feed to the laser core.
REQ-007 Ports core_done in 1 and core_c in 16 {C1X,C1Y,C2X,C2Y}: core completion and result.
REQ-008 Ports res_valid out 1, res_ready in 1, res_c out 16: result handshake to host.
REQ-009 Ports busy out 1, err out 1, frame_cnt out 8: status.

Function
REQ-010 SHALL implement states IDLE, FILL, START, STREAM, WAIT, RESULT.
REQ-011 IDLE: in_ready=0; go to FILL next cycle.
REQ-012 FILL: in_ready=1; point accepted when in_valid&in_ready; written to buffer[wptr], wptr+1.
REQ-013 FILL->START on the cycle accepting point N_PTS-1; in_ready=0 from the next cycle on.
REQ-014 START: core_start=1 for exactly one cycle; rptr cleared to 0.
REQ-015 STREAM: core_x/core_y = buffer[rptr] on N_PTS consecutive cycles, rptr 0..N_PTS-1; no gaps, no stalls.
REQ-016 core_x/core_y SHALL be 0 in every state other than STREAM.
REQ-017 STREAM->WAIT after the cycle presenting rptr=N_PTS-1; timeout counter cleared to 0.
REQ-018 WAIT: counter increments each cycle; core_done=1 captures core_c into res_c, goes to RESULT.
REQ-019 WAIT timeout: counter reaching TMO without core_done sets err=1, res_c=16'hFFFF, goes to RESULT.
REQ-020 core_done and timeout in the same cycle: core_done wins, err unchanged.
REQ-021 core_done outside WAIT SHALL be ignored.
REQ-022 RESULT: res_valid=1; res_c stable while res_valid=1 and res_ready=0.
REQ-023 res_valid&res_ready: frame_cnt+1 (wraps 255->0), wptr cleared, go to FILL next cycle.
REQ-024 busy=1 in START, STREAM, WAIT; 0 otherwise.
REQ-025 err sticky; cleared only by reset or by the first point accepted in a new FILL.
REQ-026 Points presented while in_ready=0 SHALL NOT be written or counted.
REQ-027 Buffer N_PTS x 8 bits; contents undefined after reset, only valid entries read.

Reset
REQ-028 RST=0 forces state IDLE, in_ready=0, core_start=0, core_x=core_y=0, res_valid=0, res_c=0, busy=0, err=0, frame_cnt=0, wptr=rptr=0, timeout counter=0.
REQ-029 Reset mid-frame (any state) discards the partial frame; no result output; restart in IDLE after RST=1.
REQ-030 First FILL cycle SHALL be the second rising edge after RST deassertion.

Verification
REQ-031 Full frame: 40 points (x=i%16, y=(3i)%16), in_valid held 1 -> core_start one cycle after 40th accept, then 40 cycles core_x=i%16, core_y=(3i)%16 in order.
REQ-032 Host gaps: in_valid toggled 1/0 each cycle -> exactly 40 points stored, stream identical to REQ-031, in_ready=0 after 40th.
REQ-033 Result: core_done=1 with core_c=16'h3A5C 10 cycles into WAIT -> res_valid=1, res_c=16'h3A5C held through 5 cycles of res_ready=0, frame_cnt 0->1 on accept.
REQ-034 Timeout: TMO=20, core_done never asserted -> err=1, res_c=16'hFFFF, res_valid=1 after 20 WAIT cycles; err clears on next frame's first accept.
REQ-035 Reset mid-STREAM: RST=0 at rptr=17 -> all outputs at reset values immediately; next frame streams from point 0 of newly supplied data.
REQ-036 Wrap: 256 frames completed -> frame_cnt=0; core_done pulses during FILL/STREAM ignored (no res_valid).
